// File: rtl/mux_cfgchain_routing_if.sv
// Bundle for the configurable routing mux: chain, data path and status signals.
// Latency: wires only; all timing lives in mux_cfgchain_routing.
// Backpressure: none; the chain is driven by the programming controller every cycle.
// Ports (master drives / slave receives):
//   cfg_shift_en, cfg_commit, ccff_head, in   master -> slave
//   ccff_tail, out, mem, mem_inv              slave  -> master
//   cfg_valid, cfg_err                        slave  -> master
interface mux_cfgchain_routing_if #(
  parameter int NUM_INPUTS = 8
);
  logic                  cfg_shift_en;
  logic                  cfg_commit;
  logic                  ccff_head;
  logic                  ccff_tail;
  logic [NUM_INPUTS-1:0] in;
  logic                  out;
  logic [NUM_INPUTS-1:0] mem;
  logic [NUM_INPUTS-1:0] mem_inv;
  logic                  cfg_valid;
  logic                  cfg_err;

  modport master (
    output cfg_shift_en, cfg_commit, ccff_head, in,
    input  ccff_tail, out, mem, mem_inv, cfg_valid, cfg_err
  );

  modport slave (
    input  cfg_shift_en, cfg_commit, ccff_head, in,
    output ccff_tail, out, mem, mem_inv, cfg_valid, cfg_err
  );
endinterface

// File: rtl/mux_cfgchain_routing.sv
// N-input routing mux with serial config chain and atomic commit into an active select.
// Latency: in->out combinational; ccff_head->ccff_tail exactly MEM_W prog_clk cycles.
// Backpressure: none; illegal or colliding commits are dropped and flagged on cfg_err.
// Ports: prog_clk (rising edge), pReset_n (async active-low), bus (slave modport):
//   chain  : cfg_shift_en, cfg_commit, ccff_head -> ccff_tail
//   data   : in -> out, decoded select on mem / mem_inv
//   status : cfg_valid (exactly one input selected), cfg_err (sticky bad commit)
module mux_cfgchain_routing #(
  parameter int NUM_INPUTS  = 8,
  parameter bit ENCODED     = 1'b0,
  parameter bit DEFAULT_OUT = 1'b0
) (
  input  logic                  prog_clk,
  input  logic                  pReset_n,
  mux_cfgchain_routing_if.slave bus
);

  localparam int MEM_W = ENCODED ? $clog2(NUM_INPUTS + 1) : NUM_INPUTS;

  logic [MEM_W-1:0]      sr_q, sr_d;
  logic [MEM_W-1:0]      active_q, active_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  legal;
  logic [NUM_INPUTS-1:0] mem;

  // Legality of the staged word and decode of the active word depend on the encoding.
  if (ENCODED) begin : g_enc
    localparam logic [MEM_W-1:0] MAX_SEL = MEM_W'(NUM_INPUTS);
    assign legal = (sr_q <= MAX_SEL);
    // Code k selects input k-1; code 0 selects nothing.
    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_dec
      assign mem[k] = (active_q == MEM_W'(k + 1));
    end
  end else begin : g_oh
    // Zero or one bit set: clearing the lowest set bit must leave nothing.
    assign legal = ((sr_q & (sr_q - MEM_W'(1))) == '0);
    assign mem   = active_q;
  end

  always_comb begin
    sr_d     = sr_q;
    active_d = active_q;
    valid_d  = valid_q;
    err_d    = err_q;
    if (bus.cfg_shift_en) begin
      sr_d = {sr_q[MEM_W-2:0], bus.ccff_head};
      // A commit on a shift edge would capture a half-moved word; drop it.
      if (bus.cfg_commit) begin
        err_d = 1'b1;
      end
    end else if (bus.cfg_commit) begin
      if (legal) begin
        active_d = sr_q;
        valid_d  = |sr_q;
        err_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sr_q     <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // mem is at most one-hot, so an AND-OR reduce is a correct mux.
  assign bus.out       = (|mem) ? |(bus.in & mem) : DEFAULT_OUT;
  assign bus.mem       = mem;
  assign bus.mem_inv   = ~mem;
  assign bus.ccff_tail = sr_q[MEM_W-1];
  assign bus.cfg_valid = valid_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_mux_cfgchain_routing.sv
// Directed bench for the routing mux: one-hot 8-input and encoded 5-input instances.
// Latency: inputs change at negedge, outputs sampled at negedge or shortly after.
// Backpressure: none; every step advances a bounded number of clock edges.
module tb_mux_cfgchain_routing;

  logic prog_clk = 1'b0;
  logic pReset_n;
  int   total  = 0;
  int   passed = 0;

  always #5 prog_clk = ~prog_clk;

  mux_cfgchain_routing_if #(.NUM_INPUTS(8)) ifa ();
  mux_cfgchain_routing_if #(.NUM_INPUTS(5)) ifb ();

  mux_cfgchain_routing #(.NUM_INPUTS(8), .ENCODED(1'b0), .DEFAULT_OUT(1'b0)) u_oh (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .bus      (ifa)
  );

  mux_cfgchain_routing #(.NUM_INPUTS(5), .ENCODED(1'b1), .DEFAULT_OUT(1'b1)) u_enc (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .bus      (ifb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic shift_a(input logic b);
    ifa.ccff_head    = b;
    ifa.cfg_shift_en = 1'b1;
    @(negedge prog_clk);
    ifa.cfg_shift_en = 1'b0;
  endtask

  task automatic load_a(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) shift_a(w[i]);
  endtask

  task automatic commit_a();
    ifa.cfg_commit = 1'b1;
    @(negedge prog_clk);
    ifa.cfg_commit = 1'b0;
  endtask

  task automatic shift_b(input logic b);
    ifb.ccff_head    = b;
    ifb.cfg_shift_en = 1'b1;
    @(negedge prog_clk);
    ifb.cfg_shift_en = 1'b0;
  endtask

  task automatic load_b(input logic [2:0] w);
    for (int i = 2; i >= 0; i--) shift_b(w[i]);
  endtask

  task automatic commit_b();
    ifb.cfg_commit = 1'b1;
    @(negedge prog_clk);
    ifb.cfg_commit = 1'b0;
  endtask

  initial begin
    logic [19:0] pat;
    pat = 20'hB3A5C;

    pReset_n         = 1'b0;
    ifa.cfg_shift_en = 1'b0;
    ifa.cfg_commit   = 1'b0;
    ifa.ccff_head    = 1'b0;
    ifa.in           = 8'h00;
    ifb.cfg_shift_en = 1'b0;
    ifb.cfg_commit   = 1'b0;
    ifb.ccff_head    = 1'b0;
    ifb.in           = 5'h1F;
    #3;

    // Reset state
    chk("rst_a_mem",     ifa.mem,       8'h00);
    chk("rst_a_mem_inv", ifa.mem_inv,   8'hFF);
    chk("rst_a_out",     ifa.out,       1'b0);
    chk("rst_a_tail",    ifa.ccff_tail, 1'b0);
    chk("rst_a_valid",   ifa.cfg_valid, 1'b0);
    chk("rst_a_err",     ifa.cfg_err,   1'b0);
    chk("rst_b_mem_inv", ifb.mem_inv,   5'h1F);
    chk("rst_b_out",     ifb.out,       1'b1);

    @(negedge prog_clk);
    pReset_n = 1'b1;

    // One-hot load of input 3
    load_a(8'h08);
    chk("s1_mem_before_commit", ifa.mem, 8'h00);
    commit_a();
    ifa.in = 8'hA5;
    #1;
    chk("s1_mem",   ifa.mem,       8'h08);
    chk("s1_out0",  ifa.out,       1'b0);
    chk("s1_valid", ifa.cfg_valid, 1'b1);
    chk("s1_err",   ifa.cfg_err,   1'b0);
    ifa.in = 8'h08;
    #1;
    chk("s1_out1",  ifa.out,       1'b1);

    // Two-hot word is rejected; active select untouched while shifting and after
    load_a(8'h12);
    chk("s2_mem_during_load", ifa.mem, 8'h08);
    chk("s2_tail",            ifa.ccff_tail, 1'b0);
    commit_a();
    chk("s2_err",   ifa.cfg_err,   1'b1);
    chk("s2_mem",   ifa.mem,       8'h08);
    chk("s2_out",   ifa.out,       1'b1);
    chk("s2_valid", ifa.cfg_valid, 1'b1);
    load_a(8'h00);
    commit_a();
    ifa.in = 8'hFF;
    #1;
    chk("s2_zero_err",     ifa.cfg_err,   1'b0);
    chk("s2_zero_valid",   ifa.cfg_valid, 1'b0);
    chk("s2_zero_out",     ifa.out,       1'b0);
    chk("s2_zero_mem_inv", ifa.mem_inv,   8'hFF);

    // Encoded instance: code 5 selects input 4, code 7 is out of range
    load_b(3'd5);
    commit_b();
    ifb.in = 5'b10000;
    #1;
    chk("s3_mem",   ifb.mem,       5'b10000);
    chk("s3_out1",  ifb.out,       1'b1);
    chk("s3_valid", ifb.cfg_valid, 1'b1);
    ifb.in = 5'b01111;
    #1;
    chk("s3_out0",  ifb.out,       1'b0);
    load_b(3'd7);
    commit_b();
    chk("s3_err",     ifb.cfg_err, 1'b1);
    chk("s3_mem_hold", ifb.mem,    5'b10000);
    load_b(3'd0);
    commit_b();
    chk("s3_zero_mem",   ifb.mem,       5'b00000);
    chk("s3_zero_out",   ifb.out,       1'b1);
    chk("s3_zero_valid", ifb.cfg_valid, 1'b0);
    chk("s3_zero_err",   ifb.cfg_err,   1'b0);

    // Shift and commit on the same edge: shift wins, commit dropped
    load_a(8'h04);
    commit_a();
    chk("s4_pre_mem", ifa.mem, 8'h04);
    load_a(8'h40);
    ifa.ccff_head    = 1'b0;
    ifa.cfg_shift_en = 1'b1;
    ifa.cfg_commit   = 1'b1;
    @(negedge prog_clk);
    ifa.cfg_shift_en = 1'b0;
    ifa.cfg_commit   = 1'b0;
    chk("s4_mem_hold", ifa.mem,       8'h04);
    chk("s4_err",      ifa.cfg_err,   1'b1);
    chk("s4_tail",     ifa.ccff_tail, 1'b1);
    commit_a();
    chk("s4_shifted_mem", ifa.mem,     8'h80);
    chk("s4_err_clear",   ifa.cfg_err, 1'b0);

    // Stream 20 bits: tail replays head MEM_W=8 cycles later
    ifa.cfg_shift_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ifa.ccff_head = pat[i];
      @(negedge prog_clk);
      if (i >= 7) chk($sformatf("s5_tail_%0d", i), ifa.ccff_tail, pat[i-7]);
    end
    ifa.cfg_shift_en = 1'b0;
    chk("s5_mem_hold", ifa.mem,     8'h80);
    chk("s5_err",      ifa.cfg_err, 1'b0);

    // Asynchronous reset in the middle of a load
    ifa.in = 8'h80;
    #1;
    chk("s6_out_pre", ifa.out, 1'b1);
    for (int i = 0; i < 4; i++) shift_a(1'b1);
    #2;
    pReset_n = 1'b0;
    #1;
    chk("s6_rst_out",     ifa.out,       1'b0);
    chk("s6_rst_mem_inv", ifa.mem_inv,   8'hFF);
    chk("s6_rst_tail",    ifa.ccff_tail, 1'b0);
    chk("s6_rst_valid",   ifa.cfg_valid, 1'b0);
    @(negedge prog_clk);
    pReset_n = 1'b1;
    load_a(8'h08);
    commit_a();
    ifa.in = 8'hA5;
    #1;
    chk("s6_mem",   ifa.mem,       8'h08);
    chk("s6_out0",  ifa.out,       1'b0);
    chk("s6_valid", ifa.cfg_valid, 1'b1);
    chk("s6_err",   ifa.cfg_err,   1'b0);
    ifa.in = 8'h08;
    #1;
    chk("s6_out1",  ifa.out,       1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
